vga_reg_refresh_arbiter: RTL and testbench

- Owns the single port of the shared 8-bit time/configuration register RAM. Arbitrates it between the host requester (RTC/keypad control FSM) and an internal refresh scanner.
- Once per frame, during the VSync-low window, the scanner copies RAM addresses FIRST_ADDR..LAST_ADDR into the VGA pointer/overlay block over its MemAddrIN/MemDataIN/Write interface.
- Sits between the RTC control logic, the register RAM and the VGA display path.

---
 rtl/vga_regmap_pkg.sv | 28 ++
 rtl/vga_refresh_scanner.sv | 108 ++++++++++
 rtl/vga_reg_refresh_arbiter.sv | 82 ++++++++
 tb/tb_vga_reg_refresh_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_regmap_pkg.sv
// Register map shared by the refresh arbiter, the display block and the RTC control FSM.
// Time/config registers occupy 40..51; the scanner copies that range to the display each frame.
package vga_regmap_pkg;

    localparam logic [7:0] ADDR_SEG_RELOJ  = 8'd40;
    localparam logic [7:0] ADDR_MIN_RELOJ  = 8'd41;
    localparam logic [7:0] ADDR_HORA_RELOJ = 8'd42;
    localparam logic [7:0] ADDR_DIA        = 8'd43;
    localparam logic [7:0] ADDR_MES        = 8'd44;
    localparam logic [7:0] ADDR_ANIO       = 8'd45;
    localparam logic [7:0] ADDR_SEG_CRONO  = 8'd46;
    localparam logic [7:0] ADDR_MIN_CRONO  = 8'd47;
    localparam logic [7:0] ADDR_HORA_CRONO = 8'd48;
    localparam logic [7:0] ADDR_CURSOR     = 8'd49;
    localparam logic [7:0] ADDR_ALARMA     = 8'd50;
    localparam logic [7:0] ADDR_ACT_CRONO  = 8'd51;

    localparam int FIRST_ADDR_DEF = 40;
    localparam int LAST_ADDR_DEF  = 51;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_CAPT = 2'd2,
        ST_WR   = 2'd3
    } scan_state_t;

endpackage

// File: rtl/vga_refresh_scanner.sv
// Per-frame copier of the register range into the display block during the VSync-low window.
// IDLE: wait window | READ: issue RAM read | CAPT: latch data | WR: pulse disp_write
module vga_refresh_scanner
    import vga_regmap_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int FIRST_ADDR = FIRST_ADDR_DEF,
    parameter int LAST_ADDR  = LAST_ADDR_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              VSync,
    input  logic              host_req,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              scan_rd,
    output logic [ADDR_W-1:0] scan_addr,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_write,
    output logic              frame_done,
    output logic [7:0]        miss_cnt
);

    localparam logic [ADDR_W-1:0] FIRST_A = FIRST_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] LAST_A  = LAST_ADDR[ADDR_W-1:0];

    scan_state_t       state_q;
    logic              vs_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] disp_addr_q;
    logic [DATA_W-1:0] disp_data_q;
    logic              disp_write_q;
    logic              frame_done_q;
    logic [7:0]        miss_q;
    logic [7:0]        miss_d;
    logic              win_start;

    assign win_start = vs_q & ~VSync;
    assign miss_d    = (miss_q == 8'hFF) ? miss_q : miss_q + 8'd1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            vs_q         <= 1'b0;
            ptr_q        <= FIRST_A;
            disp_addr_q  <= '0;
            disp_data_q  <= '0;
            disp_write_q <= 1'b0;
            frame_done_q <= 1'b0;
            miss_q       <= 8'd0;
        end else begin
            vs_q         <= VSync;
            disp_write_q <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (win_start) begin
                        ptr_q   <= FIRST_A;
                        state_q <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (VSync) begin
                        state_q <= ST_IDLE;
                        miss_q  <= miss_d;
                    end else if (!host_req) begin
                        state_q <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    if (VSync) begin
                        state_q <= ST_IDLE;
                        miss_q  <= miss_d;
                    end else begin
                        disp_data_q  <= ram_rdata;
                        disp_addr_q  <= ptr_q;
                        disp_write_q <= 1'b1;
                        frame_done_q <= (ptr_q == LAST_A);
                        state_q      <= ST_WR;
                    end
                end
                ST_WR: begin
                    // The pulse is already on the wire; only an unfinished frame counts as a miss.
                    if (ptr_q == LAST_A) begin
                        state_q <= ST_IDLE;
                    end else if (VSync) begin
                        state_q <= ST_IDLE;
                        miss_q  <= miss_d;
                    end else begin
                        ptr_q   <= ptr_q + 1'b1;
                        state_q <= ST_READ;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign scan_rd    = (state_q == ST_READ);
    assign scan_addr  = ptr_q;
    assign disp_addr  = disp_addr_q;
    assign disp_data  = disp_data_q;
    assign disp_write = disp_write_q;
    assign frame_done = frame_done_q;
    assign miss_cnt   = miss_q;

endmodule

// File: rtl/vga_reg_refresh_arbiter.sv
// Single-port owner of the register RAM: host always wins, the refresh scanner uses idle cycles.
module vga_reg_refresh_arbiter
    import vga_regmap_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int FIRST_ADDR = FIRST_ADDR_DEF,
    parameter int LAST_ADDR  = LAST_ADDR_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              VSync,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_write,
    output logic              frame_done,
    output logic [7:0]        miss_cnt
);

    logic              scan_rd;
    logic [ADDR_W-1:0] scan_addr;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    vga_refresh_scanner #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .FIRST_ADDR(FIRST_ADDR),
        .LAST_ADDR (LAST_ADDR)
    ) u_scanner (
        .CLK       (CLK),
        .RESET     (RESET),
        .VSync     (VSync),
        .host_req  (host_req),
        .ram_rdata (ram_rdata),
        .scan_rd   (scan_rd),
        .scan_addr (scan_addr),
        .disp_addr (disp_addr),
        .disp_data (disp_data),
        .disp_write(disp_write),
        .frame_done(frame_done),
        .miss_cnt  (miss_cnt)
    );

    // Address and write data park on their last driven value when nobody uses the port.
    always_comb begin
        ram_addr  = addr_q;
        ram_we    = 1'b0;
        ram_wdata = wdata_q;
        if (host_req) begin
            ram_addr  = host_addr;
            ram_we    = host_we;
            ram_wdata = host_wdata;
        end else if (scan_rd) begin
            ram_addr = scan_addr;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            addr_q  <= ram_addr;
            wdata_q <= ram_wdata;
        end
    end

    assign host_gnt   = host_req;
    assign host_rdata = ram_rdata;

endmodule

// File: tb/tb_vga_reg_refresh_arbiter.sv
// Bench for vga_reg_refresh_arbiter: window table, corner sequences and randomized frames.
module tb_vga_reg_refresh_arbiter;
    import vga_regmap_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       VSync;
    logic       host_req, host_we;
    logic [7:0] host_addr, host_wdata;
    logic       host_gnt;
    logic [7:0] host_rdata;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic [7:0] disp_addr, disp_data;
    logic       disp_write, frame_done;
    logic [7:0] miss_cnt;

    always #5 CLK = ~CLK;

    vga_reg_refresh_arbiter dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .VSync     (VSync),
        .host_req  (host_req),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_wdata(host_wdata),
        .host_gnt  (host_gnt),
        .host_rdata(host_rdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .disp_addr (disp_addr),
        .disp_data (disp_data),
        .disp_write(disp_write),
        .frame_done(frame_done),
        .miss_cnt  (miss_cnt)
    );

    // Register RAM with one-cycle read latency
    logic [7:0] mem [256];
    always @(posedge CLK) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        int addr;
        int data;
        int cyc;
    } dw_t;

    typedef struct {
        int         len;
        int         hs;
        int         hl;
        logic       hwe;
        logic [7:0] haddr;
        logic [7:0] hwdata;
        int         exp_n;
        int         exp_done;
        int         exp_miss;
        int         stall_k;
        int         stall;
    } vec_t;

    logic [7:0] shadow [256];
    dw_t        dq[$];
    vec_t       vecs [8];
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         fd_cnt = 0;
    int         fd0;
    int         w0;
    int         miss_model = 0;
    logic       rd_pend = 1'b0;
    logic [7:0] rd_exp;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (!RESET) begin
            check("host_gnt", {31'd0, host_gnt}, {31'd0, host_req});
            if (host_req) begin
                check("ram_addr_host", {24'd0, ram_addr}, {24'd0, host_addr});
                check("ram_we_host", {31'd0, ram_we}, {31'd0, host_we});
                if (host_we) check("ram_wdata_host", {24'd0, ram_wdata}, {24'd0, host_wdata});
            end else begin
                check("ram_we_idle", {31'd0, ram_we}, 32'd0);
            end
            if (disp_write) dq.push_back('{int'(disp_addr), int'(disp_data), cyc});
            if (frame_done) begin
                fd_cnt++;
                check("fd_disp_write", {31'd0, disp_write}, 32'd1);
                check("fd_disp_addr", {24'd0, disp_addr}, 32'd51);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
        if (rd_pend) begin
            check("host_rdata", {24'd0, host_rdata}, {24'd0, rd_exp});
            rd_pend = 1'b0;
        end
    endtask

    task automatic host_idle();
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = 8'd0;
        host_wdata = 8'd0;
    endtask

    task automatic host_op(input logic we, input logic [7:0] a, input logic [7:0] d);
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = a;
        host_wdata = d;
        if (we) shadow[a] = d;
        else begin
            rd_pend = 1'b1;
            rd_exp  = shadow[a];
        end
    endtask

    task automatic run_window(input int len, input int hs, input int hl, input logic hwe,
                              input logic [7:0] haddr, input logic [7:0] hwdata, input bit rnd);
        int         hcnt;
        logic [7:0] a;
        hcnt = 0;
        dq.delete();
        fd0 = fd_cnt;
        VSync = 1'b0;
        for (int c = 0; c < len; c++) begin
            host_idle();
            if (c >= hs && c < hs + hl) host_op(hwe, haddr, hwdata);
            else if (rnd && hcnt < 60 && $urandom_range(0, 3) == 0) begin
                a = 8'($urandom);
                if ($urandom_range(0, 1) == 1) host_op(1'b0, a, 8'd0);
                else begin
                    if (a >= 8'd40 && a <= 8'd51) a = a + 8'd20;
                    host_op(1'b1, a, 8'($urandom));
                end
                hcnt++;
            end
            step();
            if (c == 0) w0 = cyc;
        end
        host_idle();
        VSync = 1'b1;
        step();
        step();
        step();
    endtask

    task automatic check_window(input int exp_n, input int exp_done, input int miss_inc,
                                input int stall_k, input int stall, input bit timed);
        check("n_disp_writes", dq.size(), exp_n);
        for (int k = 0; k < dq.size() && k < 12; k++) begin
            check("disp_addr", dq[k].addr, 40 + k);
            check("disp_data", dq[k].data, {24'd0, shadow[40 + k]});
            if (timed) check("disp_write_cycle", dq[k].cyc - w0, 3 * k + 2 + ((k >= stall_k) ? stall : 0));
        end
        check("frame_done_cnt", fd_cnt - fd0, exp_done);
        miss_model = (miss_model + miss_inc > 255) ? 255 : miss_model + miss_inc;
        check("miss_cnt", {24'd0, miss_cnt}, miss_model);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_disp_addr"}, {24'd0, disp_addr}, 32'd0);
        check({tag, "_disp_data"}, {24'd0, disp_data}, 32'd0);
        check({tag, "_disp_write"}, {31'd0, disp_write}, 32'd0);
        check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
        check({tag, "_miss_cnt"}, {24'd0, miss_cnt}, 32'd0);
        check({tag, "_ram_we"}, {31'd0, ram_we}, 32'd0);
        check({tag, "_ram_addr"}, {24'd0, ram_addr}, 32'd0);
        check({tag, "_ram_wdata"}, {24'd0, ram_wdata}, 32'd0);
    endtask

    initial begin
        // len, hs, hl, hwe, haddr, hwdata, exp_n, exp_done, exp_miss, stall_k, stall
        vecs[0] = '{60, -1, 0, 1'b0, 8'd0,  8'h00, 12, 1, 0, 12, 0};
        vecs[1] = '{60, 13, 5, 1'b0, 8'd7,  8'h00, 12, 1, 0,  4, 5};
        vecs[2] = '{60,  5, 1, 1'b1, 8'd42, 8'h23, 12, 1, 0, 12, 0};
        vecs[3] = '{16, -1, 0, 1'b0, 8'd0,  8'h00,  5, 0, 1, 12, 0};
        vecs[4] = '{60, -1, 0, 1'b0, 8'd0,  8'h00, 12, 1, 0, 12, 0};
        vecs[5] = '{36, -1, 0, 1'b0, 8'd0,  8'h00, 12, 1, 0, 12, 0};
        vecs[6] = '{35, -1, 0, 1'b0, 8'd0,  8'h00, 11, 0, 1, 12, 0};
        vecs[7] = '{1,  -1, 0, 1'b0, 8'd0,  8'h00,  0, 0, 1, 12, 0};

        RESET = 1'b1;
        VSync = 1'b1;
        host_idle();
        step();
        step();
        step();
        check_reset_outputs("reset");
        RESET = 1'b0;

        for (int a = 0; a < 256; a++) begin
            host_op(1'b1, 8'(a), (a >= 40 && a <= 51) ? 8'(8'h10 + a - 40) : 8'($urandom));
            step();
        end
        host_idle();
        step();

        for (int i = 0; i < 8; i++) begin
            run_window(vecs[i].len, vecs[i].hs, vecs[i].hl, vecs[i].hwe, vecs[i].haddr, vecs[i].hwdata, 1'b0);
            check_window(vecs[i].exp_n, vecs[i].exp_done, vecs[i].exp_miss, vecs[i].stall_k, vecs[i].stall, 1'b1);
        end
        check("host_write_seen_by_display", {24'd0, shadow[42]}, 32'h23);

        // 256 aborted windows drive the miss counter into saturation
        for (int i = 0; i < 256; i++) begin
            run_window(1, -1, 0, 1'b0, 8'd0, 8'd0, 1'b0);
            miss_model = (miss_model + 1 > 255) ? 255 : miss_model + 1;
        end
        check("miss_cnt_saturated", {24'd0, miss_cnt}, miss_model);
        check("miss_model_sat", miss_model, 255);

        // Reset while the scanner is reading address 47
        VSync = 1'b0;
        for (int c = 0; c < 22; c++) step();
        RESET = 1'b1;
        step();
        check_reset_outputs("midscan_reset");
        RESET = 1'b0;
        VSync = 1'b1;
        miss_model = 0;
        step();
        step();
        run_window(60, -1, 0, 1'b0, 8'd0, 8'd0, 1'b0);
        check_window(12, 1, 0, 12, 0, 1'b1);

        for (int w = 0; w < 30; w++) begin
            int len;
            if ($urandom_range(0, 1) == 1) begin
                len = $urandom_range(1, 45);
                run_window(len, -1, 0, 1'b0, 8'd0, 8'd0, 1'b0);
                check_window((len / 3 > 12) ? 12 : len / 3, (len >= 36) ? 1 : 0,
                             (len < 36) ? 1 : 0, 12, 0, 1'b1);
            end else begin
                run_window(150, -1, 0, 1'b0, 8'd0, 8'd0, 1'b1);
                check_window(12, 1, 0, 12, 0, 1'b0);
            end
            for (int g = $urandom_range(1, 4); g > 0; g--) begin
                host_op(1'b1, 8'($urandom), 8'($urandom));
                step();
            end
            host_idle();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
